// File: rtl/sd_digit_capture_pkg.sv
// Shared types and constants for the SD-card digit capture block.
// Holds the controller state encoding, the ASCII digit bounds and the SD block size.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_INIT = 3'd0,
        ST_READY     = 3'd1,
        ST_READING   = 3'd2,
        ST_CHECK     = 3'd3,
        ST_ERROR     = 3'd4
    } state_e;

    localparam logic [7:0] ASCII_0        = 8'h30;
    localparam logic [7:0] ASCII_9        = 8'h39;
    localparam int unsigned SD_BLOCK_BYTES = 512;

    function automatic logic is_ascii_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/sd_digit_capture_if.sv
// Block-read handshake between the digit capture block and the SD-card controller.
// The capture block is the master: it requests reads and consumes the byte stream.
interface sd_digit_capture_if;

    logic       sd_ready;
    logic       sd_error;
    logic       rd_req;
    logic [7:0] dout;
    logic       dout_valid;
    logic       rd_done;

    modport master (
        output rd_req,
        input  sd_ready, sd_error, dout, dout_valid, rd_done
    );

    modport slave (
        input  rd_req,
        output sd_ready, sd_error, dout, dout_valid, rd_done
    );

endinterface

// File: rtl/sd_digit_capture_timeout_counter.sv
// Read watchdog: counts enabled cycles and flags the last allowed one.
// tc is high while enabled on cycle TIMEOUT_CYCLES-1 after a clear.
module timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int unsigned    CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc = en && (cnt_q == LAST);

    always_comb begin
        // NOTE: assign a default before any branch so the comb block never infers a latch.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sd_digit_capture.sv
// Requests one SD block read per button press, captures the byte at BYTE_OFFSET and
// presents it as a decimal digit for the display; supervises SD faults and read timeout.
module sd_digit_capture
    import sd_pkg::*;
#(
    parameter int unsigned BYTE_OFFSET    = 0,
    parameter int unsigned BLOCK_BYTES    = SD_BLOCK_BYTES,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    sd_digit_capture_if.master         sd,
    input  logic                       rd_btn,
    input  logic                       clr_err,
    output logic [3:0]                 digit,
    output logic                       show_digit,
    output logic                       init_ok,
    output logic                       error_flag
);

    localparam logic [9:0]  OFFSET_IDX = 10'(BYTE_OFFSET);
    localparam logic [10:0] BLOCK_LIM  = 11'(BLOCK_BYTES);

    state_e     state_q, state_d;
    logic [9:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] cap_q, cap_d;
    logic       cap_hit_q, cap_hit_d;
    logic       rd_req_q, rd_req_d;
    logic [3:0] digit_q, digit_d;
    logic       show_q, show_d;
    logic       init_ok_q, init_ok_d;
    logic       error_q, error_d;

    logic       timeout_tc;
    logic       start_read;
    logic       beat_ok;
    logic       digit_ok;

    assign start_read = (state_q == ST_READY) && (state_d == ST_READING);
    assign beat_ok    = (state_q == ST_READING) && sd.dout_valid
                        && ({1'b0, byte_cnt_q} < BLOCK_LIM);
    assign digit_ok   = cap_hit_q && is_ascii_digit(cap_q);

    timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == ST_READING),
        .clr   (start_read),
        .tc    (timeout_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_WAIT_INIT;
            byte_cnt_q <= '0;
            cap_q      <= '0;
            cap_hit_q  <= 1'b0;
            rd_req_q   <= 1'b0;
            digit_q    <= '0;
            show_q     <= 1'b0;
            init_ok_q  <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            cap_q      <= cap_d;
            cap_hit_q  <= cap_hit_d;
            rd_req_q   <= rd_req_d;
            digit_q    <= digit_d;
            show_q     <= show_d;
            init_ok_q  <= init_ok_d;
            error_q    <= error_d;
        end
    end

    // SD fault overrides everything; a dropped sd_ready aborts before rd_done or timeout.
    always_comb begin
        state_d = state_q;
        if (sd.sd_error) begin
            state_d = ST_ERROR;
        end else begin
            unique case (state_q)
                ST_WAIT_INIT: if (sd.sd_ready) state_d = ST_READY;
                ST_READY: begin
                    if (!sd.sd_ready)  state_d = ST_WAIT_INIT;
                    else if (rd_btn)   state_d = ST_READING;
                end
                ST_READING: begin
                    if (!sd.sd_ready)     state_d = ST_WAIT_INIT;
                    else if (sd.rd_done)  state_d = ST_CHECK;
                    else if (timeout_tc)  state_d = ST_ERROR;
                end
                ST_CHECK:     state_d = digit_ok ? ST_READY : ST_ERROR;
                ST_ERROR:     if (clr_err) state_d = ST_WAIT_INIT;
                default:      state_d = ST_WAIT_INIT;
            endcase
        end
    end

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        cap_d      = cap_q;
        cap_hit_d  = cap_hit_q;
        digit_d    = digit_q;
        show_d     = show_q;
        rd_req_d   = start_read;
        init_ok_d  = state_d inside {ST_READY, ST_READING, ST_CHECK};
        error_d    = (state_d == ST_ERROR);

        if (start_read) begin
            byte_cnt_d = '0;
            cap_hit_d  = 1'b0;
        end else if (beat_ok) begin
            byte_cnt_d = byte_cnt_q + 10'd1;
            if (byte_cnt_q == OFFSET_IDX) begin
                cap_d     = sd.dout;
                cap_hit_d = 1'b1;
            end
        end

        // The digit only changes on a successful check; it is blanked on abort or error.
        if (state_d == ST_ERROR || state_d == ST_WAIT_INIT) begin
            show_d = 1'b0;
        end else if (state_q == ST_CHECK && state_d == ST_READY) begin
            digit_d = 4'(cap_q - ASCII_0);
            show_d  = 1'b1;
        end
    end

    assign sd.rd_req   = rd_req_q;
    assign digit       = digit_q;
    assign show_digit  = show_q;
    assign init_ok     = init_ok_q;
    assign error_flag  = error_q;

endmodule

// File: doc/sd_digit_capture.md
Name: sd_digit_capture

Overview:
- Sits between the SD-card block-read controller and the 7-segment display driver.
- On a user read request, issues one block-read request to the SD controller and counts the returned byte stream.
- Captures the byte at a fixed offset, checks that it is an ASCII decimal digit, and holds the result as a 4-bit digit with show/status flags for the display.
- Also supervises SD init/error status and a read timeout.

Parameters:
- BYTE_OFFSET, 0, index (0..511) of the byte within the 512-byte block that is captured.
- BLOCK_BYTES, 512, number of data beats in one block read.
- TIMEOUT_CYCLES, 50_000_000, max cycles from rd_req to rd_done before error (1 s at 50 MHz).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sd_ready  in  1  SD controller init complete (level)
- sd_error  in  1  SD controller fault (level)
- rd_btn  in  1  single-cycle read request pulse, already debounced
- clr_err  in  1  single-cycle pulse; clears error state
- rd_req  out  1  one-cycle pulse requesting a block read from the SD controller
- dout  in  8  read data byte
- dout_valid  in  1  dout valid this cycle
- rd_done  in  1  one-cycle pulse at end of block read
- digit  out  4  captured digit, 0..9
- show_digit  out  1  digit holds a valid capture
- init_ok  out  1  SD initialised and no error
- error_flag  out  1  error latched

Behaviour:
- Reset values:
  - Outputs rd_req, digit, show_digit, init_ok and error_flag reset to 0.
  - State resets to WAIT_INIT; byte counter, timeout counter, capture register and cap_hit reset to 0.
- States: WAIT_INIT, READY, READING, CHECK, ERROR.
  - WAIT_INIT: go to READY when sd_ready=1.
  - READY: on rd_btn, pulse rd_req for exactly 1 cycle; clear byte counter, timeout counter and cap_hit; go to READING. show_digit and digit keep their previous values.
  - READING:
    - Each dout_valid beat with byte_cnt < BLOCK_BYTES increments byte_cnt (10-bit).
    - A beat with byte_cnt == BYTE_OFFSET loads the capture register and sets cap_hit.
    - Beats at byte_cnt >= BLOCK_BYTES are ignored.
    - rd_done goes to CHECK. If dout_valid is high in the same cycle, that beat is counted and captured first.
    - rd_btn is ignored while READING.
  - CHECK (1 cycle):
    - If cap_hit=1 and capture is in 8'h30..8'h39: digit <= capture - 8'h30 (low 4 bits), show_digit <= 1, go to READY.
    - Otherwise (non-digit byte, or short block that never reached BYTE_OFFSET): show_digit <= 0, error_flag <= 1, go to ERROR.
  - ERROR: error_flag=1, show_digit=0. clr_err clears error_flag and goes to WAIT_INIT.
- Timeout: counter runs only in READING. When it reaches TIMEOUT_CYCLES-1 without rd_done, go to ERROR. If rd_done arrives on that same cycle, rd_done wins.
- sd_error=1 in any state:
  - Go to ERROR next cycle; highest priority over rd_done, rd_btn and timeout.
  - While sd_error stays high, clr_err is ignored and the block remains in ERROR.
- sd_ready falling while in READY or READING (without sd_error): go to WAIT_INIT, show_digit <= 0, no error.
- init_ok is registered: 1 exactly when state is READY, READING or CHECK.
- Latency: rd_btn to rd_req is 1 cycle. rd_done to valid digit/show_digit is 2 cycles (CHECK, then register update visible).
- Reset asserted mid-read: all state is dropped immediately. Beats arriving after reset release are ignored until the next rd_req.

Decomposition:
- Shared package sd_pkg:
  - state enum encoding (3 bits);
  - constants ASCII_0=8'h30, ASCII_9=8'h39;
  - SD_BLOCK_BYTES=512.
- One natural sub-module, timeout_counter: enable, clear, terminal-count pulse, parameterised by TIMEOUT_CYCLES.
- Capture, check and FSM stay in the top level.

Test Plan:
- Init then read: sd_ready=1, rd_btn, stream 512 bytes with byte[0]=8'h37, then rd_done -> rd_req pulses once; digit=7, show_digit=1, init_ok=1, error_flag=0 two cycles after rd_done.
- Non-digit: BYTE_OFFSET=0, byte[0]=8'h41 -> error_flag=1, show_digit=0, init_ok=0; clr_err returns to WAIT_INIT, then READY on next cycle.
- Timeout: TIMEOUT_CYCLES=100, rd_btn, no rd_done -> error_flag=1 exactly 100 cycles after entering READING; dout beats after that are ignored.
- Short block, overrun and simultaneous edge (BYTE_OFFSET=5):
  - 3 beats then rd_done -> error.
  - 600 beats with byte[5]=8'h32 -> digit=2, extra beats ignored.
  - rd_done coincident with final valid beat -> that beat is counted.
- sd_error priority: assert sd_error during READING, in the same cycle as rd_done with a valid digit -> ERROR, show_digit=0; clr_err while sd_error=1 keeps ERROR.
- Reset mid-read: drop rst_n at beat 200 -> all outputs 0 asynchronously; after release, WAIT_INIT; stray rd_done ignored.
